// File: rtl/req_conditioner.sv
// Request front end: synchronizes and debounces raw buttons, turns presses into
// sticky pending requests, retires them on arbiter grants, and flags overruns.
module req_conditioner #(
  parameter int unsigned N      = 4,
  parameter int unsigned LN     = $clog2(N),
  parameter int unsigned DB_CNT = 50000,
  parameter int unsigned CW     = $clog2(DB_CNT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  btn_raw,
  input  logic          consume,
  input  logic [LN-1:0] grant,
  input  logic          valid,
  output logic [N-1:0]  req,
  output logic [N-1:0]  btn_db,
  output logic [N-1:0]  overrun
);

  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CNT - 1);

  logic [N-1:0]  s1;
  logic [N-1:0]  s2;
  logic [N-1:0]  btn_dq;
  logic [CW-1:0] cnt     [N];
  logic [CW-1:0] cnt_nxt [N];
  logic [N-1:0]  db_nxt;
  logic [N-1:0]  press;
  logic [N-1:0]  clr;
  logic [N-1:0]  req_nxt;
  logic [N-1:0]  ovr_nxt;

  // Debounce: a level is accepted only after DB_CNT consecutive disagreeing samples.
  always_comb begin
    db_nxt = btn_db;
    for (int i = 0; i < int'(N); i++) begin
      cnt_nxt[i] = '0;
      if (s2[i] != btn_db[i]) begin
        if (cnt[i] == CNT_MAX) begin
          db_nxt[i] = s2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  // Pending requests: a new press wins over a same-cycle retire of that line.
  always_comb begin
    press = btn_db & ~btn_dq;
    clr   = '0;
    for (int i = 0; i < int'(N); i++) begin
      clr[i] = consume & valid & (grant == LN'(i));
    end
    req_nxt = press | (req & ~clr);
    ovr_nxt = overrun | (press & req & ~clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1      <= '0;
      s2      <= '0;
      btn_db  <= '0;
      btn_dq  <= '0;
      req     <= '0;
      overrun <= '0;
      for (int i = 0; i < int'(N); i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1      <= btn_raw;
      s2      <= s1;
      btn_db  <= db_nxt;
      btn_dq  <= btn_db;
      req     <= req_nxt;
      overrun <= ovr_nxt;
      for (int i = 0; i < int'(N); i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_req_conditioner.sv
// Bench for req_conditioner: directed scenarios plus random bouncy buttons and
// grants, checked every cycle against a window-based behavioural model.
module tb_req_conditioner;

  localparam int unsigned N  = 4;
  localparam int unsigned LN = 2;
  localparam int          DB = 4;

  logic          clk;
  logic          rst;
  logic [N-1:0]  btn_raw;
  logic          consume;
  logic [LN-1:0] grant;
  logic          valid;
  logic [N-1:0]  req;
  logic [N-1:0]  btn_db;
  logic [N-1:0]  overrun;

  int tests = 0;
  int fails = 0;

  // Model state: accepted levels, previous accepted levels, requests, overruns.
  logic [N-1:0] m_db, m_dq, m_req, m_ovr;
  logic [N-1:0] hist[$];
  int           ecount;
  int           last_chg[N];

  req_conditioner #(.N(N), .LN(LN), .DB_CNT(DB)) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .consume(consume),
    .grant(grant), .valid(valid), .req(req), .btn_db(btn_db), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_db = '0; m_dq = '0; m_req = '0; m_ovr = '0;
    hist.delete();
    for (int k = 0; k < DB + 2; k++) hist.push_back('0);
    ecount = 0;
    for (int i = 0; i < int'(N); i++) last_chg[i] = -1000;
  endtask

  // One clock: drive inputs, advance model at the edge, check all outputs.
  task automatic step(input logic [N-1:0] r, input logic c, input logic v,
                      input logic [LN-1:0] g);
    logic [N-1:0] press, clr, db_n;
    bit ok;
    btn_raw = r; consume = c; valid = v; grant = g;
    @(posedge clk);
    press = m_db & ~m_dq;
    clr = '0;
    if (c && v) clr[g] = 1'b1;
    m_ovr = m_ovr | (press & m_req & ~clr);
    m_req = press | (m_req & ~clr);
    db_n = m_db;
    for (int i = 0; i < int'(N); i++) begin
      // Accept when the last DB synchronized samples all disagree and are all
      // newer than the previous acceptance.
      ok = (ecount - last_chg[i]) >= DB;
      for (int k = 1; k <= DB; k++) begin
        if (hist[hist.size() - 1 - k][i] == m_db[i]) ok = 1'b0;
      end
      if (ok) begin
        db_n[i] = ~m_db[i];
        last_chg[i] = ecount;
      end
    end
    m_dq = m_db;
    m_db = db_n;
    hist.push_back(r);
    if (hist.size() > 16) void'(hist.pop_front());
    ecount++;
    #1;
    chk("req", req, m_req);
    chk("btn_db", btn_db, m_db);
    chk("overrun", overrun, m_ovr);
    @(negedge clk);
  endtask

  initial begin
    logic [N-1:0] lvl;
    int hold[N];

    rst = 1'b1; btn_raw = '0; consume = 1'b0; grant = '0; valid = 1'b0;
    #2;
    chk("reset_req", req, 4'b0000);
    chk("reset_db", btn_db, 4'b0000);
    chk("reset_ovr", overrun, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Clean press on line 1: btn_db after edge 5, req after edge 6.
    for (int e = 0; e < 8; e++) begin
      step(4'b0010, 1'b0, 1'b0, 2'd0);
      if (e == 4) chk("latency_db_early", btn_db, 4'b0000);
      if (e == 5) begin
        chk("latency_db", btn_db, 4'b0010);
        chk("latency_req_early", req, 4'b0000);
      end
      if (e == 6) chk("latency_req", req, 4'b0010);
    end

    // Bounce on line 0 never gets accepted.
    step(4'b0011, 1'b0, 1'b0, 2'd0);
    step(4'b0010, 1'b0, 1'b0, 2'd0);
    step(4'b0011, 1'b0, 1'b0, 2'd0);
    step(4'b0010, 1'b0, 1'b0, 2'd0);
    for (int e = 0; e < 8; e++) step(4'b0010, 1'b0, 1'b0, 2'd0);
    chk("bounce_req", req, 4'b0010);
    chk("bounce_db", btn_db, 4'b0010);

    // Retire line 2: valid without consume holds, one consume clears.
    for (int e = 0; e < 8; e++) step(4'b0110, 1'b0, 1'b0, 2'd0);
    chk("retire_setup", req, 4'b0110);
    for (int e = 0; e < 5; e++) step(4'b0110, 1'b0, 1'b1, 2'd2);
    chk("retire_hold", req, 4'b0110);
    step(4'b0110, 1'b1, 1'b0, 2'd2);
    chk("consume_no_valid", req, 4'b0110);
    step(4'b0110, 1'b1, 1'b1, 2'd2);
    chk("retire_clear", req, 4'b0010);
    for (int e = 0; e < 8; e++) step(4'b0010, 1'b0, 1'b0, 2'd0);

    // Overrun on line 3: second press while still pending.
    for (int e = 0; e < 8; e++) step(4'b1010, 1'b0, 1'b0, 2'd0);
    for (int e = 0; e < 8; e++) step(4'b0010, 1'b0, 1'b0, 2'd0);
    for (int e = 0; e < 8; e++) step(4'b1010, 1'b0, 1'b0, 2'd0);
    chk("overrun_set", overrun, 4'b1000);
    chk("overrun_req", req, 4'b1010);
    for (int e = 0; e < 6; e++) step(4'b1010, 1'b1, 1'b1, 2'd3);
    chk("overrun_sticky", overrun, 4'b1000);

    // Collision on line 2: press and retire on the same edge.
    for (int e = 0; e < 8; e++) step(4'b1110, 1'b0, 1'b0, 2'd0);
    for (int e = 0; e < 8; e++) step(4'b1010, 1'b0, 1'b0, 2'd0);
    for (int e = 0; e < 6; e++) step(4'b1110, 1'b0, 1'b0, 2'd0);
    step(4'b1110, 1'b1, 1'b1, 2'd2);
    chk("collision_req", req & 4'b0100, 4'b0100);
    chk("collision_ovr", overrun & 4'b0100, 4'b0000);

    // Async reset mid-debounce, then re-debounce of held buttons.
    for (int e = 0; e < 8; e++) step(4'b0000, 1'b0, 1'b0, 2'd0);
    for (int e = 0; e < 4; e++) step(4'b1011, 1'b0, 1'b0, 2'd0);
    rst = 1'b1;
    #1;
    chk("async_req", req, 4'b0000);
    chk("async_db", btn_db, 4'b0000);
    chk("async_ovr", overrun, 4'b0000);
    model_reset();
    #1;
    rst = 1'b0;
    for (int e = 0; e < 8; e++) begin
      step(4'b1011, 1'b0, 1'b0, 2'd0);
      if (e == 5) chk("rearm_req_early", req, 4'b0000);
      if (e == 6) chk("rearm_req", req, 4'b1011);
    end

    // Random bouncy buttons with random grants.
    lvl = 4'b1011;
    for (int i = 0; i < int'(N); i++) hold[i] = 0;
    for (int e = 0; e < 600; e++) begin
      for (int i = 0; i < int'(N); i++) begin
        if (hold[i] == 0) begin
          lvl[i] = ~lvl[i];
          hold[i] = int'($urandom_range(1, 9));
        end
        hold[i]--;
      end
      step(lvl, ($urandom % 3) == 0, ($urandom % 2) == 0, LN'($urandom % 4));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/req_conditioner.md
Name: req_conditioner

Overview:
- Upstream front end of the arbiter path. Takes N raw, asynchronous, bouncy push-button request lines.
- Per line: synchronizes, debounces, and turns each press into a sticky pending request. The resulting req vector drives the arbiter's req input.
- Watches the arbiter's grant/valid at the arbiter's enable strobe and retires the granted request. Flags presses that arrive while the same line is still pending.

Parameters:
- N, 4, number of requesters
- LN, $clog2(N), width of grant index
- DB_CNT, 50000, consecutive cycles a synchronized level must differ from the debounced level before it is accepted; legal range >=1
- CW, $clog2(DB_CNT+1), debounce counter width

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- btn_raw  in  N  raw button levels, asynchronous, 1 = pressed
- consume  in  1  single-cycle strobe marking the cycle in which the arbiter samples; the same strobe as the arbiter clock enable
- grant  in  LN  arbiter grant index
- valid  in  1  arbiter grant valid
- req  out  N  pending requests to arbiter
- btn_db  out  N  debounced button levels
- overrun  out  N  sticky: a press arrived while that line was already pending

Behaviour:
- Reset: one clock domain (clk); rst is asynchronous, active-high. Asserting rst clears all state immediately, regardless of clk: sync flops, debounce counters, btn_db, edge register, req, overrun all 0.
  - Release is synchronous to the next clk edge; no special deassertion sequencing is required inside the block.
  - A press in progress at reset is lost. If the button is still held after reset, it is re-debounced from 0 and accepted as a new press.
- Synchronizer: two flops per bit, s1 <= btn_raw, s2 <= s1. No logic between s1 and s2.
- Debounce, per bit i, independent counters:
  - s2==btn_db[i]: cnt <= 0.
  - s2!=btn_db[i] and cnt<DB_CNT-1: cnt <= cnt+1.
  - s2!=btn_db[i] and cnt==DB_CNT-1: btn_db[i] <= s2, cnt <= 0.
  - Any glitch back to the btn_db level before acceptance restarts the count from 0. Release is debounced identically.
- Press detect: btn_dq <= btn_db; press[i] = btn_db[i] & ~btn_dq[i], one cycle wide.
- Latency: btn_raw rising, sampled into s1 at edge t and held clean → btn_db rises at edge t+DB_CNT+1 → req rises at edge t+DB_CNT+2.
- Retire: clr[i] = consume & valid & (grant==i). grant values >= N when N is not a power of 2 clear nothing.
- Pending update per bit, next req[i]:
  - press[i]: 1. Set wins over a simultaneous clr[i]; the new press is kept.
  - else clr[i]: 0.
  - else hold.
- Overrun: overrun[i] <= 1 when press[i] & req[i] & ~clr[i]. Cleared only by rst. A press in the same cycle as its own retire is not an overrun.
- Interlock: consume without valid changes nothing. valid without consume changes nothing, so grant may sit stable for many cycles without repeated clears.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- DB_CNT=4, N=4. rst pulse, then btn_raw=4'b0010 held, sampled at edge 0 → btn_db[1]=1 after edge 5, req=4'b0010 after edge 6, no other bits change.
- Bounce: btn_raw[0] toggles 1,0,1,0 on successive cycles then goes low → btn_db[0] and req[0] stay 0; counter never reaches 3.
- Retire: req=4'b0110, grant=2, valid=1, consume=0 for 5 cycles → req unchanged. Then a one-cycle consume → req=4'b0010 on the next edge.
- Overrun: req[3]=1, a second debounced press on line 3 with no consume → req[3] stays 1, overrun=4'b1000, which persists until rst.
- Collision: press[2] and consume&valid&grant==2 in the same cycle → req[2] stays 1, overrun[2] stays 0.
- Async reset: assert rst mid-debounce (cnt=2) between clock edges → all outputs 0 before the next edge. After release, a held button produces req 6 edges later.
